// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : multi-port register file with two combinational read ports,
//              two write ports (A = ALU writeback, B = load / multi-cycle
//              return), a per-register pending scoreboard and a runtime
//              clear sequencer that re-initialises every register.
//
// Ports
//   clk                  sole clock, all state updates on rising edge
//   reset                synchronous active-low reset
//   addr1/addr2          read addresses
//   data1/data2          read data (combinational)
//   busy1/busy2          read operand is still pending on port B
//   wr/addr3/data3       write port A (wins over port B on the same address)
//   wr_b/addr_b/data_b   write port B (also clears the pending bit)
//   lock/lock_addr       mark a register pending on port B
//   clr_req              start a runtime clear of the whole file
//   clr_busy             clear sequence running
//
// Register 0 reads as zero and ignores writes.  Register SP_IDX is
// initialised to SP_INIT by reset and by the clear sequence.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter int                SP_IDX  = 29,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h7ffffffc),
    parameter int                BYPASS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [DATA_W-1:0] data3,
    input  logic              wr_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              lock,
    input  logic [ADDR_W-1:0] lock_addr,
    output logic              busy1,
    output logic              busy2,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             idx_q, idx_d;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
    logic [DEPTH-1:0]              pending_q, pending_d;

    logic idle;
    logic bypass_en;
    logic clear_all;

    assign idle      = (state_q == ST_IDLE);
    // Forwarding only makes sense while writes are honoured, i.e. in IDLE.
    assign bypass_en = (BYPASS != 0) && idle;
    // Entering CLEAR wipes the scoreboard in the same edge.
    assign clear_all = idle && clr_req;

    // -----------------------------------------------------------------------
    // Clear sequencer
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = IDX_ONE;
                end
            end
            ST_CLEAR: begin
                clr_busy = 1'b1;
                // Counter parks at 1 after the last register rather than
                // wrapping to 0.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = IDX_ONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = IDX_ONE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Per-register next state for storage and scoreboard
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign mem_d[gi]     = '0;
                assign pending_d[gi] = 1'b0;
            end else begin : g_live
                localparam logic [ADDR_W-1:0] IDX      = ADDR_W'(gi);
                localparam logic [DATA_W-1:0] INIT_VAL = (gi == SP_IDX) ? SP_INIT : '0;

                logic hit_a, hit_b, hit_clr, hit_lock;

                assign hit_a    = idle && wr   && (addr3 == IDX);
                assign hit_b    = idle && wr_b && (addr_b == IDX);
                assign hit_lock = idle && lock && (lock_addr == IDX);
                assign hit_clr  = !idle && (idx_q == IDX);

                // Port A has priority when both ports target this register.
                assign mem_d[gi] = hit_clr ? INIT_VAL :
                                   hit_a   ? data3    :
                                   hit_b   ? data_b   : mem_q[gi];

                // Lock beats the port-B return so a re-issued load keeps
                // the register pending.
                assign pending_d[gi] = clear_all ? 1'b0 :
                                       hit_lock  ? 1'b1 :
                                       hit_b     ? 1'b0 : pending_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_ONE;
            pending_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            mem_q     <= mem_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = mem_q[a];
        if (a == '0) begin
            v = '0;
        end else if (bypass_en && wr && (addr3 == a)) begin
            v = data3;
        end else if (bypass_en && wr_b && (addr_b == a)) begin
            v = data_b;
        end
        return v;
    endfunction

    // A port-B return in this cycle resolves the hazard immediately when
    // forwarding is enabled.
    function automatic logic busy_port(input logic [ADDR_W-1:0] a);
        logic b;
        b = idle && (a != '0) && pending_q[a];
        if (bypass_en && wr_b && (addr_b == a)) begin
            b = 1'b0;
        end
        return b;
    endfunction

    always_comb begin
        data1 = read_port(addr1);
        data2 = read_port(addr2);
        busy1 = busy_port(addr1);
        busy2 = busy_port(addr2);
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam logic [31:0] SP_VAL = 32'h7ffffffc;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  addr1, addr2, addr3, addr_b, lock_addr;
    logic [31:0] data1, data2, data3, data_b;
    logic        wr, wr_b, lock, busy1, busy2, clr_req, clr_busy;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk      (clk),
        .reset    (reset),
        .addr1    (addr1),
        .addr2    (addr2),
        .data1    (data1),
        .data2    (data2),
        .wr       (wr),
        .addr3    (addr3),
        .data3    (data3),
        .wr_b     (wr_b),
        .addr_b   (addr_b),
        .data_b   (data_b),
        .lock     (lock),
        .lock_addr(lock_addr),
        .busy1    (busy1),
        .busy2    (busy2),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  a3;
        logic [31:0] d3;
        logic        wrb;
        logic [4:0]  ab;
        logic [31:0] db;
        logic        lk;
        logic [4:0]  la;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr = 0; addr3 = 0; data3 = 0;
        wr_b = 0; addr_b = 0; data_b = 0;
        lock = 0; lock_addr = 0;
        clr_req = 0; addr1 = 0; addr2 = 0;
    endtask

    function automatic vec_t mk(input logic w, input logic [4:0] a3, input logic [31:0] d3,
                                input logic wb, input logic [4:0] ab, input logic [31:0] db,
                                input logic lk, input logic [4:0] la,
                                input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic eb1, input logic eb2);
        vec_t v;
        v.wr = w; v.a3 = a3; v.d3 = d3; v.wrb = wb; v.ab = ab; v.db = db;
        v.lk = lk; v.la = la; v.a1 = a1; v.a2 = a2;
        v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
        return v;
    endfunction

    vec_t vt[17];
    int   cnt;

    initial begin
        //          wr a3 d3            wrb ab db           lk la  a1  a2  e1            e2            b1 b2
        vt[0]  = mk(0, 0, 0,            0, 0, 0,            0, 0,  29, 0,  SP_VAL,       0,            0, 0);
        vt[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vt[2]  = mk(0, 0, 0,            0, 0, 0,            0, 0,  5,  4,  32'hDEADBEEF, 0,            0, 0);
        vt[3]  = mk(1, 0, 32'h1234,     0, 0, 0,            0, 0,  0,  0,  0,            0,            0, 0);
        vt[4]  = mk(1, 7, 32'h1,        1, 7, 32'h2,        0, 0,  7,  7,  32'h1,        32'h1,        0, 0);
        vt[5]  = mk(0, 0, 0,            0, 0, 0,            0, 0,  7,  29, 32'h1,        SP_VAL,       0, 0);
        vt[6]  = mk(0, 0, 0,            0, 0, 0,            1, 9,  9,  0,  0,            0,            0, 0);
        vt[7]  = mk(0, 0, 0,            0, 0, 0,            0, 0,  9,  9,  0,            0,            1, 1);
        vt[8]  = mk(0, 0, 0,            1, 9, 32'h55,       0, 0,  9,  10, 32'h55,       0,            0, 0);
        vt[9]  = mk(0, 0, 0,            0, 0, 0,            0, 0,  9,  0,  32'h55,       0,            0, 0);
        vt[10] = mk(0, 0, 0,            1, 9, 32'h66,       1, 9,  9,  0,  32'h66,       0,            0, 0);
        vt[11] = mk(0, 0, 0,            0, 0, 0,            0, 0,  9,  0,  32'h66,       0,            1, 0);
        vt[12] = mk(0, 0, 0,            1, 0, 32'h77,       1, 0,  0,  9,  0,            32'h66,       0, 1);
        vt[13] = mk(0, 0, 0,            1, 9, 32'h88,       0, 0,  3,  9,  0,            32'h88,       0, 0);
        vt[14] = mk(1, 3, 32'h12,       1, 12, 32'hAB,      0, 0,  3,  12, 32'h12,       32'hAB,       0, 0);
        vt[15] = mk(0, 0, 0,            0, 0, 0,            1, 11, 3,  12, 32'h12,       32'hAB,       0, 0);
        vt[16] = mk(0, 0, 0,            0, 0, 0,            0, 0,  11, 0,  0,            0,            1, 0);

        idle_inputs();
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;

        // Table-driven single-cycle vectors: drive at negedge, sample before next posedge.
        for (int i = 0; i < 17; i++) begin
            idle_inputs();
            wr = vt[i].wr; addr3 = vt[i].a3; data3 = vt[i].d3;
            wr_b = vt[i].wrb; addr_b = vt[i].ab; data_b = vt[i].db;
            lock = vt[i].lk; lock_addr = vt[i].la;
            addr1 = vt[i].a1; addr2 = vt[i].a2;
            #2;
            $display("vec %0d a1=%0d d1=%h b1=%0b a2=%0d d2=%h b2=%0b cb=%0b",
                     i, addr1, data1, busy1, addr2, data2, busy2, clr_busy);
            chk($sformatf("v%0d_data1", i), data1, vt[i].e1);
            chk($sformatf("v%0d_data2", i), data2, vt[i].e2);
            chk($sformatf("v%0d_busy1", i), 32'(busy1), 32'(vt[i].eb1));
            chk($sformatf("v%0d_busy2", i), 32'(busy2), 32'(vt[i].eb2));
            chk($sformatf("v%0d_clr_busy", i), 32'(clr_busy), 32'h0);
            @(negedge clk);
        end

        // Runtime clear with hostile inputs held throughout.
        idle_inputs();
        clr_req = 1;
        #2;
        chk("clr_req_cycle_clr_busy", 32'(clr_busy), 32'h0);
        @(negedge clk);
        for (int c = 1; c <= 31; c++) begin
            idle_inputs();
            clr_req = 1;
            wr = 1; addr3 = 3; data3 = 32'hFFFF;
            wr_b = 1; addr_b = 4; data_b = 32'hEEEE;
            lock = 1; lock_addr = 5;
            addr1 = 3; addr2 = 11;
            if (c == 31) clr_req = 0;
            #2;
            $display("clear c=%0d clr_busy=%0b d1=%h b2=%0b", c, clr_busy, data1, busy2);
            chk($sformatf("clear%0d_clr_busy", c), 32'(clr_busy), 32'h1);
            chk($sformatf("clear%0d_data1", c), data1, (c <= 3) ? 32'h12 : 32'h0);
            chk($sformatf("clear%0d_busy2", c), 32'(busy2), 32'h0);
            @(negedge clk);
        end
        idle_inputs();
        addr1 = 3; addr2 = 29;
        #2;
        chk("post_clear_clr_busy", 32'(clr_busy), 32'h0);
        chk("post_clear_reg3", data1, 32'h0);
        chk("post_clear_reg29", data2, SP_VAL);
        @(negedge clk);
        addr1 = 11; addr2 = 5;
        #2;
        chk("post_clear_busy11", 32'(busy1), 32'h0);
        chk("post_clear_busy5", 32'(busy2), 32'h0);
        chk("post_clear_reg5", data2, 32'h0);
        @(negedge clk);
        addr1 = 4; addr2 = 12;
        #2;
        chk("post_clear_reg4", data1, 32'h0);
        chk("post_clear_reg12", data2, 32'h0);
        $display("post clear reg4=%h reg12=%h", data1, data2);
        @(negedge clk);

        // Reset in the middle of a clear.
        idle_inputs();
        wr = 1; addr3 = 20; data3 = 32'h20;
        @(negedge clk);
        idle_inputs();
        lock = 1; lock_addr = 6;
        @(negedge clk);
        idle_inputs();
        addr1 = 20;
        #2;
        chk("pre_reset_reg20", data1, 32'h20);
        clr_req = 1;
        @(negedge clk);
        for (int c = 1; c <= 9; c++) begin
            idle_inputs();
            @(negedge clk);
        end
        idle_inputs();
        reset = 0;
        wr = 1; addr3 = 20; data3 = 32'h99;
        #2;
        chk("cycle10_clr_busy", 32'(clr_busy), 32'h1);
        @(negedge clk);
        reset = 1;
        idle_inputs();
        addr1 = 20; addr2 = 29;
        #2;
        $display("after mid-clear reset clr_busy=%0b reg20=%h reg29=%h", clr_busy, data1, data2);
        chk("rst_clr_busy", 32'(clr_busy), 32'h0);
        chk("rst_reg20", data1, 32'h0);
        chk("rst_reg29", data2, SP_VAL);
        @(negedge clk);
        addr1 = 6; addr2 = 3;
        #2;
        chk("rst_busy6", 32'(busy1), 32'h0);
        chk("rst_reg3", data2, 32'h0);
        @(negedge clk);

        // Clear length after reset: counter must restart at 1.
        idle_inputs();
        clr_req = 1;
        @(negedge clk);
        idle_inputs();
        cnt = 0;
        for (int n = 0; n < 64; n++) begin
            #2;
            if (!clr_busy) break;
            cnt++;
            @(negedge clk);
        end
        $display("clear length %0d", cnt);
        chk("clear_length", 32'(cnt), 32'd31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
